// File: rtl/activation_writeback_packer_pkg.sv
// Shared types and helpers for the activation writeback packer.
package activation_writeback_packer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } writeback_state_e;

  function automatic int beat_bytes(input int features_per_beat, input int data_width);
    return (features_per_beat * data_width) / 8;
  endfunction
endpackage

// File: rtl/activation_writeback_packer_beat_fifo.sv
// Small synchronous beat FIFO; head entry is presented combinationally so a push
// is visible on the output one cycle later.
module activation_writeback_packer_beat_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        wr_ptr_reg <= wr_ptr_reg + (PTR_W + 1)'(1);
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + (PTR_W + 1)'(1);
    end
  end
endmodule

// File: rtl/activation_writeback_packer.sv
// Packs activated features into wide beats and issues address-incrementing
// memory write requests, one start/done transaction per output row.
module activation_writeback_packer
  import activation_writeback_packer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int FEATURES_PER_BEAT = 16,
  parameter int FIFO_DEPTH        = 4,
  parameter int COUNT_WIDTH       = 16,
  parameter int ADDR_WIDTH        = 34
) (
  input  logic                                  core_clk,
  input  logic                                  resetn,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 start_address,
  input  logic [COUNT_WIDTH-1:0]                feature_count,
  input  logic                                  in_feature_valid,
  input  logic [DATA_WIDTH-1:0]                 in_feature,
  output logic                                  write_req_valid,
  input  logic                                  write_req_ready,
  output logic [ADDR_WIDTH-1:0]                 write_req_address,
  output logic [FEATURES_PER_BEAT*DATA_WIDTH-1:0] write_req_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow_error
);
  localparam int LANE_W = (FEATURES_PER_BEAT > 1) ? $clog2(FEATURES_PER_BEAT) : 1;
  localparam int BEAT_W = FEATURES_PER_BEAT * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE =
    ADDR_WIDTH'(beat_bytes(FEATURES_PER_BEAT, DATA_WIDTH));

  writeback_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0]        addr_reg;
  logic [COUNT_WIDTH-1:0]       count_reg;
  logic [COUNT_WIDTH-1:0]       received_reg;
  logic [LANE_W-1:0]            lane_idx_reg;
  logic [BEAT_W-1:0]            lane_reg;
  logic [BEAT_W-1:0]            beat_data;
  logic                         overflow_reg;
  logic                         done_reg, done_next;
  logic                         row_start, feature_accept, last_feature, beat_done;
  logic                         fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_WIDTH+BEAT_W-1:0] fifo_head;

  assign row_start      = (state_reg == IDLE) && start && (feature_count != '0);
  assign feature_accept = (state_reg == COLLECT) && in_feature_valid;
  assign last_feature   = (received_reg == count_reg - COUNT_WIDTH'(1));
  assign beat_done      = feature_accept &&
                          (last_feature || lane_idx_reg == LANE_W'(FEATURES_PER_BEAT - 1));
  assign fifo_pop       = write_req_valid && write_req_ready;

  // Lane register is zeroed after every beat, so unfilled upper lanes read as zero.
  for (genvar gi = 0; gi < FEATURES_PER_BEAT; gi++) begin : g_lane
    assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (lane_idx_reg == LANE_W'(gi)) ? in_feature : lane_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (row_start) state_next = COLLECT;
        else if (start) done_next = 1'b1;
      end
      COLLECT: if (feature_accept && last_feature) state_next = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      addr_reg     <= '0;
      count_reg    <= '0;
      received_reg <= '0;
      lane_idx_reg <= '0;
      lane_reg     <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (row_start) begin
        addr_reg     <= start_address;
        count_reg    <= feature_count;
        received_reg <= '0;
        lane_idx_reg <= '0;
        lane_reg     <= '0;
        overflow_reg <= 1'b0;
      end else if (feature_accept) begin
        received_reg <= received_reg + COUNT_WIDTH'(1);
        if (beat_done) begin
          lane_reg     <= '0;
          lane_idx_reg <= '0;
          // Address advances even for a dropped beat so later beats stay aligned.
          addr_reg     <= addr_reg + BEAT_STRIDE;
          if (fifo_full && !fifo_pop) overflow_reg <= 1'b1;
        end else begin
          lane_reg     <= beat_data;
          lane_idx_reg <= lane_idx_reg + LANE_W'(1);
        end
      end
    end
  end

  activation_writeback_packer_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + BEAT_W)
  ) u_beat_fifo (
    .core_clk  (core_clk),
    .resetn    (resetn),
    .push      (beat_done),
    .push_data ({addr_reg, beat_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign write_req_valid = !fifo_empty;
  assign {write_req_address, write_req_data} = fifo_head;
  assign busy            = (state_reg != IDLE);
  assign done            = done_reg;
  assign overflow_error  = overflow_reg;
endmodule

// File: tb/tb_activation_writeback_packer.sv
// Randomized self-checking bench for activation_writeback_packer against a
// row-level beat model (ceil(count/16) beats, 64-byte stride, zero-padded tail).
module tb_activation_writeback_packer;
  localparam int DW    = 32;
  localparam int FPB   = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int AW    = 34;
  localparam int BW    = FPB * DW;
  localparam int STRIDE = FPB * DW / 8;

  logic          core_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [CW-1:0] feature_count = '0;
  logic          in_feature_valid = 1'b0;
  logic [DW-1:0] in_feature = '0;
  logic          write_req_ready = 1'b0;
  logic          write_req_valid;
  logic [AW-1:0] write_req_address;
  logic [BW-1:0] write_req_data;
  logic          busy, done, overflow_error;

  activation_writeback_packer #(
    .DATA_WIDTH(DW), .FEATURES_PER_BEAT(FPB), .FIFO_DEPTH(DEPTH),
    .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .core_clk(core_clk), .resetn(resetn), .start(start),
    .start_address(start_address), .feature_count(feature_count),
    .in_feature_valid(in_feature_valid), .in_feature(in_feature),
    .write_req_valid(write_req_valid), .write_req_ready(write_req_ready),
    .write_req_address(write_req_address), .write_req_data(write_req_data),
    .busy(busy), .done(done), .overflow_error(overflow_error)
  );

  always #5 core_clk = ~core_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rmode = 0;  // 0 ready high, 1 ready low, 2 toggle, 3 random
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] exp_addr[$];
  logic [BW-1:0] obs_data[$];
  logic [BW-1:0] exp_data[$];
  logic [DW-1:0] row_feat[$];
  int done_count = 0;
  int done_cycle = 0;
  int last_accept_cycle = 0;
  int stall_violations = 0;
  bit busy_seen = 0;
  bit valid_seen = 0;
  bit stalled_prev = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [BW-1:0] prev_data = '0;

  // Observe the bus mid-cycle: inputs and outputs are stable until the next edge.
  always @(negedge core_clk) begin
    if (resetn) begin
      if (stalled_prev && (!write_req_valid || write_req_address !== prev_addr ||
                           write_req_data !== prev_data))
        stall_violations++;
      if (write_req_valid && write_req_ready) begin
        obs_addr.push_back(write_req_address);
        obs_data.push_back(write_req_data);
        last_accept_cycle = cyc;
      end
      if (done) begin
        done_count++;
        done_cycle = cyc;
      end
      if (busy) busy_seen = 1;
      if (write_req_valid) valid_seen = 1;
      stalled_prev = write_req_valid && !write_req_ready;
      prev_addr = write_req_address;
      prev_data = write_req_data;
    end else begin
      stalled_prev = 0;
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic next_ready();
    case (rmode)
      0: return 1'b1;
      1: return 1'b0;
      2: return cyc[0];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    stall_violations = 0;
    busy_seen = 0;
    valid_seen = 0;
  endtask

  // Reference: beat b carries features 16b..16b+15 at addr + 64b; only the first
  // 'keep' beats survive when nothing drains the FIFO.
  task automatic build_expect(input logic [AW-1:0] addr, input int count, input int keep);
    int nb;
    logic [BW-1:0] d;
    exp_addr.delete();
    exp_data.delete();
    nb = (count + FPB - 1) / FPB;
    for (int b = 0; b < nb && b < keep; b++) begin
      d = '0;
      for (int k = 0; k < FPB; k++)
        if (b * FPB + k < count) d[k*DW +: DW] = row_feat[b*FPB + k];
      exp_addr.push_back(addr + AW'(b * STRIDE));
      exp_data.push_back(d);
    end
  endtask

  task automatic fill_random(input int n);
    row_feat.delete();
    for (int i = 0; i < n; i++) row_feat.push_back($urandom);
  endtask

  task automatic drive_row(input logic [AW-1:0] addr, input int count, input int gap_pct,
                           input bit poke, input int max_feat);
    int idx;
    start = 1'b1;
    start_address = addr;
    feature_count = CW'(count);
    in_feature_valid = 1'b1;  // stray feature while IDLE must be ignored
    in_feature = 32'hDEAD_BEEF;
    write_req_ready = next_ready();
    tick();
    start = 1'b0;
    idx = 0;
    while (idx < count && idx < max_feat) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_feature_valid = 1'b0;
        in_feature = $urandom;
      end else begin
        in_feature_valid = 1'b1;
        in_feature = row_feat[idx];
        idx++;
      end
      if (poke && idx == 3) begin
        start = 1'b1;
        start_address = 34'h3_FFFF_0000;
        feature_count = 5;
      end else begin
        start = 1'b0;
      end
      write_req_ready = next_ready();
      tick();
    end
    in_feature_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int dc0;
    dc0 = done_count;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      write_req_ready = next_ready();
      tick();
      if (done_count != dc0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (overflow_error !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow_error); end
    total++; if (write_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", write_req_valid); end
    total++; if (write_req_address !== '0 || write_req_data !== '0) begin
      bad++; $display("FAIL reset_addr_data: got addr %h data %h want 0", write_req_address, write_req_data);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    bit ok;
    int dc0;
    row_feat.delete();
    for (int i = 0; i < FPB; i++) row_feat.push_back(DW'(i + 1));
    clear_obs(); dc0 = done_count; rmode = 0;
    drive_row(34'h1000, 16, 0, 0, 16);
    wait_done(200, ok);
    repeat (3) tick();
    build_expect(34'h1000, 16, 1000);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no done want done"); end
    total++; if (done_count - dc0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_count - dc0); end
    total++; if (done_cycle - last_accept_cycle !== 2) begin
      bad++; $display("FAIL single_done_latency: got %0d want 2 (cycles after accept sample)", done_cycle - last_accept_cycle);
    end
    total++;
    if (obs_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL single_beats: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL single_beat%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    $display("single_beat: beats=%0d done=%0d", obs_addr.size(), done_count - dc0);
  endtask

  task automatic test_partial_beat();
    bit ok;
    int dc0;
    row_feat.delete();
    for (int i = 0; i < 20; i++) row_feat.push_back(DW'(i + 1));
    clear_obs(); dc0 = done_count; rmode = 0;
    drive_row(34'h2000, 20, 0, 0, 20);
    wait_done(200, ok);
    repeat (3) tick();
    build_expect(34'h2000, 20, 1000);
    total++; if (!ok) begin bad++; $display("FAIL partial_timeout: got no done want done"); end
    total++; if (done_count - dc0 !== 1) begin bad++; $display("FAIL partial_done_count: got %0d want 1", done_count - dc0); end
    total++;
    if (obs_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL partial_beats: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL partial_beat%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    $display("partial_beat: beats=%0d done=%0d", obs_addr.size(), done_count - dc0);
  endtask

  task automatic test_zero_count();
    int dc0;
    clear_obs(); dc0 = done_count; rmode = 0;
    write_req_ready = 1'b1;
    start = 1'b1;
    start_address = 34'h3000;
    feature_count = '0;
    tick();
    start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_pulse: got %b want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done); end
    repeat (5) tick();
    total++; if (busy_seen !== 1'b0 || valid_seen !== 1'b0) begin
      bad++; $display("FAIL zero_quiet: got busy_seen=%b valid_seen=%b want 0/0", busy_seen, valid_seen);
    end
    total++; if (done_count - dc0 !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_count - dc0); end
    $display("zero_count: done=%0d", done_count - dc0);
  endtask

  task automatic test_overflow();
    bit ok;
    int dc0;
    fill_random(96);
    clear_obs(); dc0 = done_count; rmode = 1;
    drive_row(34'h0, 96, 0, 0, 96);
    repeat (5) tick();
    build_expect(34'h0, 96, DEPTH);
    total++; if (busy !== 1'b1 || done_count !== dc0) begin
      bad++; $display("FAIL ovf_wait_drain: got busy=%b dones=%0d want 1/0", busy, done_count - dc0);
    end
    total++; if (overflow_error !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow_error); end
    total++; if (write_req_valid !== 1'b1 || write_req_address !== exp_addr[0]) begin
      bad++; $display("FAIL ovf_head: got valid=%b addr %h want 1/%h", write_req_valid, write_req_address, exp_addr[0]);
    end
    rmode = 0;
    wait_done(200, ok);
    repeat (2) tick();
    total++; if (!ok) begin bad++; $display("FAIL ovf_timeout: got no done want done"); end
    total++; if (overflow_error !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow_error); end
    total++;
    if (obs_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL ovf_beats: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL ovf_beat%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    $display("overflow: beats=%0d overflow_error=%b", obs_addr.size(), overflow_error);
  endtask

  task automatic test_stall_toggle();
    bit ok;
    fill_random(64);
    clear_obs(); rmode = 2;
    drive_row(34'h4000, 64, 0, 0, 64);
    wait_done(300, ok);
    repeat (2) tick();
    build_expect(34'h4000, 64, 1000);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no done want done"); end
    total++; if (stall_violations !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_violations); end
    total++; if (overflow_error !== 1'b0) begin bad++; $display("FAIL stall_overflow: got %b want 0", overflow_error); end
    total++;
    if (obs_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL stall_beats: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL stall_beat%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    $display("stall_toggle: beats=%0d stall_changes=%0d", obs_addr.size(), stall_violations);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dc0;
    fill_random(40);
    clear_obs(); rmode = 0;
    drive_row(34'h500, 40, 0, 0, 7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || overflow_error !== 1'b0 || write_req_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags: got busy=%b done=%b ovf=%b valid=%b want 0", busy, done, overflow_error, write_req_valid);
    end
    total++; if (write_req_address !== '0 || write_req_data !== '0) begin
      bad++; $display("FAIL rstmid_addr_data: got %h/%h want 0", write_req_address, write_req_data);
    end
    tick(); tick();
    resetn = 1'b1;
    tick();
    fill_random(16);
    clear_obs(); dc0 = done_count;
    drive_row(34'h7C0, 16, 0, 1, 16);
    wait_done(200, ok);
    repeat (10) tick();
    build_expect(34'h7C0, 16, 1000);
    total++; if (!ok || done_count - dc0 !== 1) begin
      bad++; $display("FAIL rstmid_done: got ok=%b dones=%0d want 1/1", ok, done_count - dc0);
    end
    total++;
    if (obs_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL rstmid_beats: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL rstmid_beat%0d: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    $display("reset_mid: beats=%0d done=%0d", obs_addr.size(), done_count - dc0);
  endtask

  task automatic test_random_rows();
    bit ok;
    int dc0;
    int n;
    logic [AW-1:0] a;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 80);
      a = {$urandom_range(0, 3), $urandom};
      fill_random(n);
      clear_obs(); dc0 = done_count; rmode = 3;
      drive_row(a, n, 30, 0, n);
      wait_done(400, ok);
      repeat (2) tick();
      build_expect(a, n, 1000);
      total++; if (!ok || done_count - dc0 !== 1 || overflow_error !== 1'b0) begin
        bad++; $display("FAIL rand%0d_done: got ok=%b dones=%0d ovf=%b want 1/1/0", r, ok, done_count - dc0, overflow_error);
      end
      total++;
      if (obs_addr.size() !== exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_beats: got %0d want %0d", r, obs_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          total++;
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL rand%0d_beat%0d: got %h/%h want %h/%h", r, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      $display("random row %0d: count=%0d addr=%h beats=%0d", r, n, a, obs_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_partial_beat();
    test_zero_count();
    test_overflow();
    test_stall_toggle();
    test_reset_mid();
    test_random_rows();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
